input_stream_skewer: RTL and testbench

//  Feeds activation rows into the systolic array during the controller's COMPUTE phase.
//  On each rising edge of ctrl_input_stream_en it reads cfg_seq_len rows from the input buffer.
//  The buffer is a synchronous RAM with 1-cycle read latency.

---
 rtl/input_stream_skewer.sv | 156 +++++++++++++++
 tb/tb_input_stream_skewer.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/input_stream_skewer.sv
// input_stream_skewer: streams activation rows from the input buffer into the
// west edge of the systolic array, skewing lane k by k cycles so the rows
// enter the array as a diagonal wavefront.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   ctrl_input_stream_en  stream window; a rising edge while idle starts a stream
//   cfg_seq_len           number of rows to stream, sampled at start
//   buf_rd_en/addr        read port of the input buffer (1-cycle read latency)
//   buf_rd_data           row returned by the buffer; lane k at [k*DATA_W +: DATA_W]
//   array_in_data/valid   skewed lane data and per-lane valid to the array
//   stream_busy           high from start until the done pulse ends
//   stream_done           one-cycle pulse once every lane has drained
module input_stream_skewer #(
    parameter int unsigned ARRAY_SIZE = 16,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned ADDR_W     = 10
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         ctrl_input_stream_en,
    input  logic [31:0]                  cfg_seq_len,
    output logic                         buf_rd_en,
    output logic [ADDR_W-1:0]            buf_rd_addr,
    input  logic [ARRAY_SIZE*DATA_W-1:0] buf_rd_data,
    output logic [ARRAY_SIZE*DATA_W-1:0] array_in_data,
    output logic [ARRAY_SIZE-1:0]        array_in_valid,
    output logic                         stream_busy,
    output logic                         stream_done
);

    // Row counter carries one extra bit so a full 2^ADDR_W stream ends cleanly.
    localparam int unsigned CNT_W   = ADDR_W + 1;
    localparam logic [31:0] MAX_ROWS = 32'(1) << ADDR_W;
    // Flush spans the read latency, the lane-0 stage and the deepest skew chain.
    localparam int unsigned FLUSH_W = $clog2(ARRAY_SIZE + 2);
    localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(ARRAY_SIZE + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t             state;
    logic               en_q;
    logic [CNT_W-1:0]   m_len;
    logic [CNT_W-1:0]   row_cnt;
    logic [FLUSH_W-1:0] flush_cnt;
    logic               rd_vld;

    logic [CNT_W-1:0]   m_clamp_c;
    logic               start_c;

    // Requested length clamped to the buffer depth.
    assign m_clamp_c = (cfg_seq_len >= MAX_ROWS) ? CNT_W'(MAX_ROWS) : CNT_W'(cfg_seq_len);
    assign start_c   = ctrl_input_stream_en && !en_q && (state == IDLE);

    // Control FSM: issues reads, waits for the skew chains to drain, pulses done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            en_q        <= 1'b0;
            m_len       <= '0;
            row_cnt     <= '0;
            flush_cnt   <= '0;
            buf_rd_en   <= 1'b0;
            buf_rd_addr <= '0;
            stream_busy <= 1'b0;
            stream_done <= 1'b0;
        end else begin
            en_q        <= ctrl_input_stream_en;
            buf_rd_en   <= 1'b0;
            stream_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_c) begin
                        stream_busy <= 1'b1;
                        m_len       <= m_clamp_c;
                        flush_cnt   <= '0;
                        if (m_clamp_c == '0) begin
                            state <= FLUSH;
                        end else begin
                            // Row 0 is issued on the start edge itself.
                            state       <= STREAM;
                            buf_rd_en   <= 1'b1;
                            buf_rd_addr <= '0;
                            row_cnt     <= CNT_W'(1);
                        end
                    end
                end
                STREAM: begin
                    // Dropping the enable aborts; rows already issued still drain.
                    if (ctrl_input_stream_en && (row_cnt < m_len)) begin
                        buf_rd_en   <= 1'b1;
                        buf_rd_addr <= row_cnt[ADDR_W-1:0];
                        row_cnt     <= row_cnt + CNT_W'(1);
                    end else begin
                        state <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (flush_cnt == FLUSH_LAST) begin
                        state       <= DONE;
                        stream_done <= 1'b1;
                    end else begin
                        flush_cnt <= flush_cnt + FLUSH_W'(1);
                    end
                end
                DONE: begin
                    state       <= IDLE;
                    stream_busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Read-valid aligned with the buffer's one-cycle read latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld <= 1'b0;
        end else begin
            rd_vld <= buf_rd_en;
        end
    end

    // Per-lane skew: stage 0 captures the buffer data (zeroed when not valid),
    // then lane k adds k more stages. Data and valid move together, so an
    // invalid lane always carries zero.
    for (genvar k = 0; k < ARRAY_SIZE; k++) begin : g_lane
        logic [DATA_W-1:0] dpipe [0:k];
        logic [k:0]        vpipe;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int s = 0; s <= k; s++) begin
                    dpipe[s] <= '0;
                end
                vpipe <= '0;
            end else begin
                dpipe[0] <= rd_vld ? buf_rd_data[k*DATA_W +: DATA_W] : '0;
                vpipe[0] <= rd_vld;
                for (int s = 1; s <= k; s++) begin
                    dpipe[s] <= dpipe[s-1];
                    vpipe[s] <= vpipe[s-1];
                end
            end
        end

        assign array_in_data[k*DATA_W +: DATA_W] = dpipe[k];
        assign array_in_valid[k]                 = vpipe[k];
    end

endmodule

// File: tb/tb_input_stream_skewer.sv
// Directed bench for input_stream_skewer with a 4-lane array and a 10-bit
// address space. A behavioural buffer returns row j lane k = {j[3:0], k[3:0]}
// and junk on non-read cycles; a negedge monitor logs lane outputs, reads and
// done pulses with their cycle index.
module tb_input_stream_skewer;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 8;
    localparam int unsigned AW = 10;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              en;
    logic [31:0]       cfg_seq_len;
    logic              buf_rd_en;
    logic [AW-1:0]     buf_rd_addr;
    logic [N*DW-1:0]   buf_rd_data;
    logic [N*DW-1:0]   array_in_data;
    logic [N-1:0]      array_in_valid;
    logic              stream_busy;
    logic              stream_done;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [DW-1:0] lane_dat [N][$];
    int            lane_cyc [N][$];
    logic [AW-1:0] rd_addr_q [$];
    int            rd_cyc_q  [$];
    int            done_q    [$];
    int            zf_bad = 0;

    input_stream_skewer #(.ARRAY_SIZE(N), .DATA_W(DW), .ADDR_W(AW)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .ctrl_input_stream_en (en),
        .cfg_seq_len          (cfg_seq_len),
        .buf_rd_en            (buf_rd_en),
        .buf_rd_addr          (buf_rd_addr),
        .buf_rd_data          (buf_rd_data),
        .array_in_data        (array_in_data),
        .array_in_valid       (array_in_valid),
        .stream_busy          (stream_busy),
        .stream_done          (stream_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [N*DW-1:0] mk_row(input logic [AW-1:0] a);
        logic [N*DW-1:0] r;
        for (int k = 0; k < N; k++) r[k*DW +: DW] = {a[3:0], 4'(k)};
        return r;
    endfunction

    // Synchronous buffer model, 1-cycle latency; junk when not read.
    always @(posedge clk) begin
        if (buf_rd_en) buf_rd_data <= mk_row(buf_rd_addr);
        else           buf_rd_data <= 32'($urandom);
    end

    always @(negedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (array_in_valid[k]) begin
                lane_dat[k].push_back(array_in_data[k*DW +: DW]);
                lane_cyc[k].push_back(cyc);
            end else if (array_in_data[k*DW +: DW] !== 8'h00) begin
                zf_bad++;
            end
        end
        if (buf_rd_en) begin
            rd_addr_q.push_back(buf_rd_addr);
            rd_cyc_q.push_back(cyc);
        end
        if (stream_done) done_q.push_back(cyc);
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_logs();
        for (int k = 0; k < N; k++) begin
            lane_dat[k].delete();
            lane_cyc[k].delete();
        end
        rd_addr_q.delete();
        rd_cyc_q.delete();
        done_q.delete();
        zf_bad = 0;
    endtask

    // Starts a stream; e0 is the cycle index following the start edge.
    task automatic run_stream(input int cfg, input int abort_at, input bit hold, output int e0);
        int lim;
        clear_logs();
        cfg_seq_len = 32'(cfg);
        en = 1'b1;
        tick();
        e0 = cyc;
        if (abort_at > 0) begin
            repeat (abort_at - 1) tick();
            en = 1'b0;
        end
        lim = 0;
        while (done_q.size() == 0 && lim < 3000) begin
            tick();
            lim++;
        end
        if (!hold) en = 1'b0;
        repeat (4) tick();
    endtask

    // Number of lane samples that deviate from the expected staircase.
    function automatic int lane_bad(input int e0, input int m);
        int bad = 0;
        logic [DW-1:0] ev;
        for (int k = 0; k < N; k++) begin
            if (lane_dat[k].size() != m) begin
                bad++;
            end else begin
                for (int j = 0; j < m; j++) begin
                    ev = {4'(j), 4'(k)};
                    if (lane_dat[k][j] !== ev || lane_cyc[k][j] != e0 + j + 2 + k) bad++;
                end
            end
        end
        return bad;
    endfunction

    // Number of reads out of address or cycle order.
    function automatic int rd_bad(input int e0, input int m);
        int bad = 0;
        if (rd_addr_q.size() != m) return 1;
        for (int j = 0; j < m; j++) begin
            if (rd_addr_q[j] !== AW'(j) || rd_cyc_q[j] != e0 + j) bad++;
        end
        return bad;
    endfunction

    function automatic int first_done();
        return (done_q.size() > 0) ? done_q[0] : -1;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        en = 1'b0;
        cfg_seq_len = '0;
        repeat (3) tick();
        checks++;
        if (array_in_valid !== '0 || array_in_data !== '0) begin
            errors++;
            $display("FAIL reset_lanes got valid=%h data=%h expected 0", array_in_valid, array_in_data);
        end
        checks++;
        if (buf_rd_en !== 1'b0 || buf_rd_addr !== '0) begin
            errors++;
            $display("FAIL reset_rd got en=%b addr=%0d expected 0", buf_rd_en, buf_rd_addr);
        end
        checks++;
        if (stream_busy !== 1'b0 || stream_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_status got busy=%b done=%b expected 0", stream_busy, stream_done);
        end
        rst_n = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_full();
        int e0, b;
        run_stream(8, 0, 1'b0, e0);
        checks++;
        if (done_q.size() != 1 || first_done() != e0 + 14) begin
            errors++;
            $display("FAIL full_done got n=%0d cyc=%0d expected n=1 cyc=%0d", done_q.size(), first_done(), e0 + 14);
        end
        b = rd_bad(e0, 8);
        checks++;
        if (b != 0) begin
            errors++;
            $display("FAIL full_reads got %0d bad (n=%0d) expected 0 bad, n=8", b, rd_addr_q.size());
        end
        b = lane_bad(e0, 8);
        checks++;
        if (b != 0) begin
            errors++;
            $display("FAIL full_lanes got %0d bad expected 0", b);
        end
        checks++;
        if (zf_bad != 0) begin
            errors++;
            $display("FAIL full_zero_fill got %0d stale samples expected 0", zf_bad);
        end
        checks++;
        if (stream_busy !== 1'b0) begin
            errors++;
            $display("FAIL full_busy_end got %b expected 0", stream_busy);
        end
    endtask

    task automatic test_single();
        int e0, b;
        run_stream(1, 0, 1'b0, e0);
        for (int k = 0; k < N; k++) begin
            checks++;
            if (lane_cyc[k].size() != 1 || lane_cyc[k][0] != e0 + 2 + k) begin
                errors++;
                $display("FAIL single_lane%0d got n=%0d cyc=%0d expected n=1 cyc=%0d", k,
                         lane_cyc[k].size(), (lane_cyc[k].size() > 0) ? lane_cyc[k][0] : -1, e0 + 2 + k);
            end
        end
        b = lane_bad(e0, 1);
        checks++;
        if (b != 0) begin
            errors++;
            $display("FAIL single_data got %0d bad expected 0", b);
        end
        checks++;
        if (done_q.size() != 1 || first_done() != e0 + 7) begin
            errors++;
            $display("FAIL single_done got n=%0d cyc=%0d expected n=1 cyc=%0d", done_q.size(), first_done(), e0 + 7);
        end
    endtask

    task automatic test_zero();
        int e0, nv;
        run_stream(0, 0, 1'b0, e0);
        nv = 0;
        for (int k = 0; k < N; k++) nv += lane_dat[k].size();
        checks++;
        if (rd_addr_q.size() != 0 || nv != 0) begin
            errors++;
            $display("FAIL zero_activity got reads=%0d valids=%0d expected 0 and 0", rd_addr_q.size(), nv);
        end
        checks++;
        if (done_q.size() != 1 || first_done() != e0 + 6) begin
            errors++;
            $display("FAIL zero_done got n=%0d cyc=%0d expected n=1 cyc=%0d", done_q.size(), first_done(), e0 + 6);
        end
    endtask

    task automatic test_abort();
        int e0, b;
        run_stream(8, 3, 1'b0, e0);
        b = rd_bad(e0, 3);
        checks++;
        if (b != 0) begin
            errors++;
            $display("FAIL abort_reads got %0d bad (n=%0d) expected 0 bad, n=3", b, rd_addr_q.size());
        end
        b = lane_bad(e0, 3);
        checks++;
        if (b != 0) begin
            errors++;
            $display("FAIL abort_lanes got %0d bad expected 0", b);
        end
        checks++;
        if (done_q.size() != 1 || first_done() != e0 + 9) begin
            errors++;
            $display("FAIL abort_done got n=%0d cyc=%0d expected n=1 cyc=%0d", done_q.size(), first_done(), e0 + 9);
        end
    endtask

    task automatic test_reset_mid();
        int e0, b;
        clear_logs();
        cfg_seq_len = 32'd8;
        en = 1'b1;
        tick();
        e0 = cyc;
        repeat (10) tick();
        // Cycle after E0+10: lane k holds row 8-k, so lane 0 has run out.
        checks++;
        if (array_in_valid !== 4'b1110) begin
            errors++;
            $display("FAIL midrst_pre_valid got %b expected 1110", array_in_valid);
        end
        #2;
        rst_n = 1'b0;
        en = 1'b0;
        #1;
        checks++;
        if (array_in_valid !== '0 || array_in_data !== '0 || stream_busy !== 1'b0 ||
            stream_done !== 1'b0 || buf_rd_en !== 1'b0) begin
            errors++;
            $display("FAIL midrst_outputs got valid=%h data=%h busy=%b done=%b rd=%b expected all 0",
                     array_in_valid, array_in_data, stream_busy, stream_done, buf_rd_en);
        end
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (10) tick();
        checks++;
        if (done_q.size() != 0 || rd_addr_q.size() != 8) begin
            errors++;
            $display("FAIL midrst_no_done got dones=%0d reads=%0d expected 0 and 8", done_q.size(), rd_addr_q.size());
        end
        run_stream(6, 0, 1'b0, e0);
        b = lane_bad(e0, 6) + rd_bad(e0, 6);
        checks++;
        if (b != 0 || first_done() != e0 + 12) begin
            errors++;
            $display("FAIL midrst_restart got %0d bad done=%0d expected 0 bad done=%0d", b, first_done(), e0 + 12);
        end
    endtask

    task automatic test_held();
        int e0;
        run_stream(5, 0, 1'b1, e0);
        repeat (20) tick();
        checks++;
        if (rd_addr_q.size() != 5 || done_q.size() != 1) begin
            errors++;
            $display("FAIL held_no_restart got reads=%0d dones=%0d expected 5 and 1", rd_addr_q.size(), done_q.size());
        end
        checks++;
        if (stream_busy !== 1'b0) begin
            errors++;
            $display("FAIL held_busy got %b expected 0", stream_busy);
        end
        en = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_clamp();
        int e0, b;
        run_stream(2000, 0, 1'b0, e0);
        b = rd_bad(e0, 1024);
        checks++;
        if (b != 0) begin
            errors++;
            $display("FAIL clamp_reads got %0d bad (n=%0d) expected 0 bad, n=1024", b, rd_addr_q.size());
        end
        checks++;
        if (rd_addr_q.size() > 0 && rd_addr_q[rd_addr_q.size()-1] !== 10'd1023) begin
            errors++;
            $display("FAIL clamp_last_addr got %0d expected 1023", rd_addr_q[rd_addr_q.size()-1]);
        end
        b = lane_bad(e0, 1024);
        checks++;
        if (b != 0) begin
            errors++;
            $display("FAIL clamp_lanes got %0d bad expected 0", b);
        end
        checks++;
        if (done_q.size() != 1 || first_done() != e0 + 1030) begin
            errors++;
            $display("FAIL clamp_done got n=%0d cyc=%0d expected n=1 cyc=%0d", done_q.size(), first_done(), e0 + 1030);
        end
    endtask

    initial begin
        test_reset();
        test_full();
        test_single();
        test_zero();
        test_abort();
        test_reset_mid();
        test_held();
        test_clamp();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
